load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-indexed data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [ADDR_LENGTH-1:0] i_addr,
  input  logic [DATA_LENGTH-1:0] i_wdata,
  input  logic [1:0]             i_size,
  input  logic                   i_signed,
  output logic                   o_rsp_valid,
  output logic [DATA_LENGTH-1:0] o_rdata,
  output logic                   o_err,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic                   o_mem_we,
  output logic                   o_mem_re,
  output logic [4:0]             o_mem_size_control,
  output logic [DATA_LENGTH-1:0] o_mem_wdata,
  input  logic [DATA_LENGTH-1:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
  state_t r_state, w_next;
  logic r_we, r_signed;
  logic [1:0] r_size;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [DATA_LENGTH-1:0] r_mem_wdata, r_rdata;
  logic w_accept, w_is_b, w_is_h, w_is_w, w_trap, w_r_b, w_r_h;
  logic [ADDR_LENGTH-1:0] w_addr;
  logic [7:0] w_b;
  logic [15:0] w_h;
  logic [DATA_LENGTH-1:0] w_load, w_merge;
  assign w_accept = i_req_valid && (r_state == IDLE);
  assign w_is_b = (i_size == 2'b01);
  assign w_is_h = (i_size == 2'b10);
  assign w_is_w = !w_is_b && !w_is_h;
  // Low address bits that cannot address a lane of this size are dropped at latch time.
  assign w_addr = {i_addr[ADDR_LENGTH-1:2], i_addr[1] & ~w_is_w, i_addr[0] & w_is_b};
`ifdef LSU_MISALIGN_TRAP_EN
  logic r_err;
  assign w_trap = (w_is_h & i_addr[0]) | (w_is_w & (|i_addr[1:0]));
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) r_err <= 1'b0;
    else if (w_accept) r_err <= w_trap;
  assign o_err = r_err;
`else
  assign w_trap = 1'b0;
  assign o_err = 1'b0;
`endif
  assign w_r_b = (r_size == 2'b01);
  assign w_r_h = (r_size == 2'b10);
  assign w_b = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_h = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];
  assign w_load = w_r_b ? {{(DATA_LENGTH-8){r_signed & w_b[7]}}, w_b}
                : w_r_h ? {{(DATA_LENGTH-16){r_signed & w_h[15]}}, w_h}
                : i_mem_rdata;
  always_comb begin
    w_merge = i_mem_rdata;
    if (w_r_b) w_merge[{r_addr[1:0], 3'b000} +: 8] = r_mem_wdata[7:0];
    else w_merge[{r_addr[1], 4'b0000} +: 16] = r_mem_wdata[15:0];
  end
  // Only full-word stores skip the read; sub-word stores read-modify-write.
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (i_req_valid ? (w_trap ? RSP : (i_req_we && w_is_w) ? WR : RD) : IDLE)
           : (r_state == RD)   ? (r_we ? WR : RSP)
           : (r_state == WR)   ? RSP
           : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we        <= i_req_we;
        r_signed    <= i_signed;
        r_size      <= i_size;
        r_addr      <= w_addr;
        r_mem_wdata <= i_wdata;
        r_rdata     <= '0;
      end else if (r_state == RD) begin
        if (r_we) r_mem_wdata <= w_merge;
        else r_rdata <= w_load;
      end
    end
  assign o_req_ready        = (r_state == IDLE);
  assign o_mem_re           = (r_state == RD);
  assign o_mem_we           = (r_state == WR);
  assign o_rsp_valid        = (r_state == RSP);
  assign o_rdata            = r_rdata;
  assign o_mem_addr         = {2'b00, r_addr[ADDR_LENGTH-1:2]};
  assign o_mem_size_control = 5'b00000;
  assign o_mem_wdata        = r_mem_wdata;
endmodule
